// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with post-reset clear sequencer and write-to-read bypass; optional busy scoreboard via REGFILE_SCOREBOARD_EN
module regfile_mp #(
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int NR       = 2,
  parameter int NW       = 2,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic             init_done,
  input  logic [NW-1:0]    we,
  input  logic [NW*AW-1:0] waddr,
  input  logic [NW*DW-1:0] wdata,
  input  logic [NR-1:0]    re,
  input  logic [NR*AW-1:0] raddr,
  output logic [NR*DW-1:0] rdata
`ifdef REGFILE_SCOREBOARD_EN
  ,
  input  logic             iss_we,
  input  logic [AW-1:0]    iss_addr,
  output logic [NR-1:0]    rbusy
`endif
);
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_nx;
  logic [AW-1:0] clr_idx;
  logic [DW-1:0] regs [DEPTH];
  logic [NW-1:0] wv;
  logic run;
  always_ff @(posedge clk)
    if (rst) begin
      state     <= INIT;
      clr_idx   <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nx;
      clr_idx   <= state == INIT ? clr_idx + 1'b1 : '0;
      init_done <= state_nx == RUN;
    end
  always_comb begin
    state_nx = (state == INIT && clr_idx == AW'(DEPTH - 1)) ? RUN : state;
    run      = state == RUN && !rst;
    wv       = '0;
    for (int k = 0; k < NW; k++)
      wv[k] = we[k] && run && !(ZERO_REG != 0 && waddr[k*AW +: AW] == '0);
  end
  // Higher-numbered port is written last so it wins a same-address collision
  always_ff @(posedge clk)
    if (!rst && state == INIT) regs[clr_idx] <= '0;
    else
      for (int k = 0; k < NW; k++)
        if (wv[k]) regs[waddr[k*AW +: AW]] <= wdata[k*DW +: DW];
  always_comb begin
    rdata = '0;
    for (int j = 0; j < NR; j++)
      if (run && re[j] && !(ZERO_REG != 0 && raddr[j*AW +: AW] == '0)) begin
        rdata[j*DW +: DW] = regs[raddr[j*AW +: AW]];
        for (int k = 0; k < NW; k++)
          if (wv[k] && waddr[k*AW +: AW] == raddr[j*AW +: AW]) rdata[j*DW +: DW] = wdata[k*DW +: DW];
      end
  end
`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] busy;
  logic [NR-1:0] hit;
  // Issue set is applied after write clears: a same-cycle issue is newer
  always_ff @(posedge clk)
    if (rst || state != RUN) busy <= '0;
    else begin
      for (int k = 0; k < NW; k++)
        if (wv[k]) busy[waddr[k*AW +: AW]] <= 1'b0;
      if (iss_we && !(ZERO_REG != 0 && iss_addr == '0)) busy[iss_addr] <= 1'b1;
    end
  always_comb begin
    hit   = '0;
    rbusy = '0;
    for (int j = 0; j < NR; j++) begin
      for (int k = 0; k < NW; k++)
        if (wv[k] && waddr[k*AW +: AW] == raddr[j*AW +: AW]) hit[j] = 1'b1;
      rbusy[j] = run && re[j] && busy[raddr[j*AW +: AW]] && !hit[j];
    end
  end
`endif
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and randomized checks of regfile_mp against a behavioural model
module tb_regfile_mp;
  localparam int DW = 32, DEPTH = 32, AW = 5, NR = 2, NW = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic init_done;
  logic [NW-1:0] we;
  logic [NW*AW-1:0] waddr;
  logic [NW*DW-1:0] wdata;
  logic [NR-1:0] re;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
`ifdef REGFILE_SCOREBOARD_EN
  logic iss_we;
  logic [AW-1:0] iss_addr;
  logic [NR-1:0] rbusy;
  bit mbusy [DEPTH];
`endif
  int n_assert = 0, n_fail = 0;
  logic [DW-1:0] model [DEPTH];
  bit mrun = 0;
  always #5 clk = ~clk;
  regfile_mp dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata)
`ifdef REGFILE_SCOREBOARD_EN
    , .iss_we(iss_we), .iss_addr(iss_addr), .rbusy(rbusy)
`endif
  );
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    we = '0; waddr = '0; wdata = '0; re = '0; raddr = '0;
`ifdef REGFILE_SCOREBOARD_EN
    iss_we = 1'b0; iss_addr = '0;
`endif
  endtask
  task automatic wr(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[k] = 1'b1; waddr[k*AW +: AW] = a; wdata[k*DW +: DW] = d;
  endtask
  task automatic rd(input int j, input logic [AW-1:0] a);
    re[j] = 1'b1; raddr[j*AW +: AW] = a;
  endtask
  function automatic logic [DW-1:0] exp_rd(input int j);
    logic [AW-1:0] a = raddr[j*AW +: AW];
    if (!mrun || !re[j] || a == 0) return '0;
    if (we[1] && waddr[AW +: AW] == a) return wdata[DW +: DW];
    if (we[0] && waddr[0 +: AW] == a) return wdata[0 +: DW];
    return model[a];
  endfunction
`ifdef REGFILE_SCOREBOARD_EN
  function automatic logic exp_busy(input int j);
    logic [AW-1:0] a = raddr[j*AW +: AW];
    bit h = (we[0] && waddr[0 +: AW] == a && a != 0) || (we[1] && waddr[AW +: AW] == a && a != 0);
    return mrun && re[j] && mbusy[a] && !h;
  endfunction
`endif
  task automatic check_reads(input string tag);
    #1;
    for (int j = 0; j < NR; j++) begin
      chk(tag, rdata[j*DW +: DW], exp_rd(j));
`ifdef REGFILE_SCOREBOARD_EN
      chk({tag, "_busy"}, {31'b0, rbusy[j]}, {31'b0, exp_busy(j)});
`endif
    end
  endtask
  task automatic step();
    @(posedge clk);
    if (mrun) begin
`ifdef REGFILE_SCOREBOARD_EN
      for (int k = 0; k < NW; k++) if (we[k]) mbusy[waddr[k*AW +: AW]] = 0;
      if (iss_we && iss_addr != 0) mbusy[iss_addr] = 1;
`endif
      for (int k = 0; k < NW; k++)
        if (we[k] && waddr[k*AW +: AW] != 0) model[waddr[k*AW +: AW]] = wdata[k*DW +: DW];
    end
    @(negedge clk);
  endtask
  task automatic init_wait(input string tag, input int n0);
    int n = n0;
    while (!init_done && n < 60) begin
      @(posedge clk); #1; n++;
    end
    chk(tag, n, DEPTH);
    for (int a = 0; a < DEPTH; a++) model[a] = '0;
`ifdef REGFILE_SCOREBOARD_EN
    for (int a = 0; a < DEPTH; a++) mbusy[a] = 0;
`endif
    mrun = 1;
    idle();
  endtask
  initial begin
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    wr(0, 5, 32'hFFFFFFFF); rd(0, 5); rd(1, 5);
    check_reads("rst_read");
    chk("rst_init_done", {31'b0, init_done}, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reads("init_read");
    chk("init_done_low", {31'b0, init_done}, 0);
    init_wait("init_len", 3);
    rd(0, 5);
    check_reads("post_init_r5");
    @(negedge clk);
    idle(); wr(0, 3, 32'hDEADBEEF); step();
    idle(); rd(0, 3); #1;
    chk("r3", rdata[0 +: DW], 32'hDEADBEEF);
    wr(0, 0, 32'h1234); rd(1, 0);
    check_reads("r0_bypass");
    step();
    idle(); rd(0, 0); #1;
    chk("r0", rdata[0 +: DW], 0);
    idle(); wr(1, 7, 32'hA5A5A5A5); rd(0, 7); rd(1, 7); #1;
    chk("bypass_l0", rdata[0 +: DW], 32'hA5A5A5A5);
    chk("bypass_l1", rdata[DW +: DW], 32'hA5A5A5A5);
    step();
    idle(); wr(0, 9, 32'h11111111); wr(1, 9, 32'h22222222); rd(0, 9); #1;
    chk("coll_bypass", rdata[0 +: DW], 32'h22222222);
    step();
    idle(); rd(1, 9); #1;
    chk("coll_array", rdata[DW +: DW], 32'h22222222);
`ifdef REGFILE_SCOREBOARD_EN
    idle(); iss_we = 1'b1; iss_addr = 4; step();
    idle(); rd(0, 4); #1;
    chk("sb_busy", {31'b0, rbusy[0]}, 1);
    wr(0, 4, 32'h55); #1;
    chk("sb_bypass", {31'b0, rbusy[0]}, 0);
    step();
    idle(); rd(0, 4); #1;
    chk("sb_cleared", {31'b0, rbusy[0]}, 0);
    iss_we = 1'b1; iss_addr = 6; wr(0, 6, 32'h77); step();
    idle(); rd(0, 6); #1;
    chk("sb_newer", {31'b0, rbusy[0]}, 1);
`endif
    repeat (300) begin
      idle();
      we = NW'($urandom);
      for (int k = 0; k < NW; k++) begin
        waddr[k*AW +: AW] = AW'($urandom_range(0, 11));
        wdata[k*DW +: DW] = $urandom;
      end
      re = NR'($urandom);
      for (int j = 0; j < NR; j++) raddr[j*AW +: AW] = AW'($urandom_range(0, 11));
`ifdef REGFILE_SCOREBOARD_EN
      iss_we = 1'($urandom_range(0, 1)); iss_addr = AW'($urandom_range(0, 11));
`endif
      check_reads("rand");
      step();
    end
    idle(); rst = 1'b1; mrun = 0; step();
    rst = 1'b0;
    repeat (10) step();
    chk("midinit_done", {31'b0, init_done}, 0);
    rst = 1'b1; step();
    rst = 1'b0;
    init_wait("reinit_len", 0);
    for (int a = 1; a < DEPTH; a++) begin
      idle(); rd(0, AW'(a)); rd(1, AW'(a));
      check_reads("cleared");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file; next generation of the single-write, dual-read regfile.
- Sits between decode (read ports) and write-back (write ports) of the pipeline.
- Adds configurable width, depth and port counts, two-way write arbitration and write-to-read bypass on every port.
- Adds a post-reset hardware clear sequencer: the array is zeroed cycle by cycle, so no simulation X state depends on initial blocks.

Parameters:
- DW, 32, data width in bits.
- DEPTH, 32, number of registers; power of two, ≥4.
- AW, $clog2(DEPTH), address width; derived, not overridden.
- NR, 2, number of read ports (1..4).
- NW, 2, number of write ports (1..2).
- ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- init_done  out  1  high once the clear sequence has finished; registered.
- we  in  NW  per write-port enable.
- waddr  in  NW*AW  write addresses; port k at bits [k*AW +: AW].
- wdata  in  NW*DW  write data; port k at bits [k*DW +: DW].
- re  in  NR  per read-port enable.
- raddr  in  NR*AW  read addresses, packed like waddr.
- rdata  out  NR*DW  read data, combinational, packed like wdata.
- iss_we  in  1  scoreboard: mark iss_addr busy (REGFILE_SCOREBOARD_EN only).
- iss_addr  in  AW  scoreboard: destination being issued (REGFILE_SCOREBOARD_EN only).
- rbusy  out  NR  scoreboard: busy flag of each raddr (REGFILE_SCOREBOARD_EN only).

Behaviour:
- State machine: INIT, RUN.
  - rst=1 at an edge: state<=INIT, clr_idx<=0, init_done<=0.
  - INIT: each cycle write 0 to regs[clr_idx], then clr_idx+1. When clr_idx==DEPTH-1, the next state is RUN and init_done<=1.
  - INIT therefore lasts exactly DEPTH cycles after rst drops.
  - rst asserted in any state, including mid-INIT, restarts INIT from index 0.
- During rst=1 or INIT:
  - All we are ignored.
  - All rdata lanes read 0.
- RUN, writes:
  - regs[waddr[k]] <= wdata[k] when we[k]=1.
  - ZERO_REG=1: writes to address 0 are dropped.
  - If both ports are enabled to the same address, port 1 wins and port 0's write is discarded.
- RUN, read lane j, priority order:
  1. re[j]=0 gives 0.
  2. ZERO_REG=1 and raddr[j]==0 gives 0.
  3. Bypass: if some enabled write port hits raddr[j], rdata gets that port's wdata; port 1 has priority over port 0.
  4. Otherwise regs[raddr[j]].
- Read latency: 0 cycles (combinational). Write-to-array latency: 1 cycle. Bypass makes a same-cycle write visible.
- Reset values:
  - init_done=0.
  - rdata=0.
  - rbusy=0.
  - Array = 0 after INIT completes.

Optional Feature:
- Macro: REGFILE_SCOREBOARD_EN.
- Defined:
  - Adds a DEPTH-bit busy vector, reset and INIT-cleared to 0.
  - iss_we=1 in RUN sets busy[iss_addr]. An enabled write to an address clears its bit.
  - A same-cycle set and clear on one address leaves it set (the issue is newer).
  - Address 0 is never busy when ZERO_REG=1.
  - rbusy[j] = busy[raddr[j]] & re[j] & ~(bypass hit on lane j).
- Undefined:
  - iss_we, iss_addr and rbusy ports are absent.
  - No busy state is built.

Test Plan:
- Clear sequence: rst=1 for 2 cycles, then 0 → init_done rises exactly DEPTH=32 cycles later. Reading r5 with re=1 during INIT gives 0; after init_done it still gives 0.
- Reset mid-INIT: assert rst at INIT cycle 10 for 1 cycle → init_done only 32 cycles after the second release.
- Write/read and zero register: write r3=0xDEADBEEF via port 0, read r3 next cycle → 0xDEADBEEF. Write r0=0x1234 → r0 still reads 0.
- Bypass: same cycle as we[1]=1, waddr1=7, wdata1=0xA5A5A5A5, read r7 on both lanes → both lanes give 0xA5A5A5A5 in that cycle.
- Write collision: port0 r9=0x11111111 and port1 r9=0x22222222 in the same cycle → bypass and the later array read both give 0x22222222.
- Scoreboard (macro on):
  - iss_we=1, iss_addr=4, then read r4 → rbusy=1.
  - Write r4=0x55 → rbusy=0 in that cycle via bypass; the busy bit is cleared on the next cycle.
  - Same-cycle issue and write of r6 → r6 remains busy.
